sobel_window_reader: RTL
========================

SOBEL_WINDOW_READER -- requirements
Module: sobel_window_reader

Interface
REQ-001 SHALL have parameter IMG_W, default 32, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 32, image height in pixels.
REQ-003 SHALL have parameter AW, default 10, gray-memory address width.
REQ-004 SHALL have parameter PW, default 4, gray pixel width.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port sobel_en, input, 1 bit: one-cycle start pulse, sampled only in IDLE.
REQ-008 SHALL have port rd_en, output, 1 bit: gray-memory read strobe.
REQ-009 SHALL have port rd_addr, output, AW bits: gray-memory read address.
REQ-010 SHALL have port rd_data, input, 3*PW bits: stored {g,g,g} word, valid one cycle after rd_en; only bits [PW-1:0] are used.
REQ-011 SHALL have port win, output, 9*PW bits: 3x3 window, row-major, p00 in LSBs.
REQ-012 SHALL have port win_addr, output, AW bits: address of the window centre pixel.
REQ-013 SHALL have port win_valid, output, 1 bit: window valid.
REQ-014 SHALL have port win_ready, input, 1 bit: consumer accepts the window.
REQ-015 SHALL have port sobel_done, output, 1 bit: one-cycle pulse after the last window transfers.

Function
REQ-016 SHALL implement FSM states IDLE, READ, FLUSH, DONE.
REQ-017 IDLE->READ on sobel_en; read address reset to 0.
REQ-018 READ SHALL issue reads at addresses 0..IMG_W*IMG_H-1 in raster order, one per cycle, when not stalled.
REQ-019 READ->FLUSH after address IMG_W*IMG_H-1 is issued.
REQ-020 FLUSH->DONE when the final window transfers; DONE->IDLE after exactly one cycle with sobel_done=1.
REQ-021 Two line buffers of IMG_W x PW entries SHALL hold the previous two rows; each returned pixel shifts the 3x3 register array.
REQ-022 A window SHALL be produced for each returned pixel at (r,c) with r>=2 and c>=2; centre is (r-1,c-1); win_addr = (r-1)*IMG_W + (c-1).
REQ-023 Exactly (IMG_W-2)*(IMG_H-2) windows per frame (900 at default); border pixels yield no window.
REQ-024 Transfer occurs on a cycle with win_valid && win_ready.
REQ-025 While win_valid && !win_ready: win and win_addr held stable, rd_en=0, rd_addr held.
REQ-026 A datum in flight during a stall SHALL be captured in a one-entry skid register and consumed first on release; no pixel may be lost or duplicated.
REQ-027 Column/row counters wrap at IMG_W-1 / IMG_H-1; a window SHALL never straddle a row boundary.
REQ-028 sobel_en outside IDLE SHALL be ignored.
REQ-029 Pixel values SHALL be passed through unmodified; no arithmetic other than address/counter increment.

Reset
REQ-030 On rst=0: state IDLE; rd_en=0, rd_addr=0, win=0, win_addr=0, win_valid=0, sobel_done=0; counters and skid register cleared.
REQ-031 Reset mid-frame SHALL abort immediately; the next frame restarts from address 0 after sobel_en.
REQ-032 Line-buffer contents need not be cleared; they SHALL not affect output, since windows begin only at r>=2.

Structure
REQ-033 State encoding, IMG_W/IMG_H/AW/PW defaults and the window index mapping SHALL live in shared package sobel_pkg.
REQ-034 A single sub-module line_buffer (IMG_W-deep PW-wide delay line) SHALL be instantiated twice.

Verification
REQ-035 Memory word = {addr[3:0] x3}, win_ready=1, sobel_en pulse -> first window win_addr=33, pixels row-major 0,1,2,0,1,2,0,1,2.
REQ-036 Same frame -> exactly 900 win_valid transfers, last win_addr=990, sobel_done high exactly one cycle after the last transfer, then IDLE.
REQ-037 win_ready held low 5 cycles at window 10 -> win/win_addr stable, rd_en=0 throughout; the following window sequence is identical to the REQ-035 run.
REQ-038 win_ready toggled every cycle -> the sequence of 900 win_addr values matches the unstalled run, with no gaps or repeats.
REQ-039 rst pulled low at window 400 -> all outputs 0 asynchronously; a new sobel_en produces a first window with win_addr=33.
REQ-040 sobel_en pulsed during READ -> no effect; window count remains 900.

Source files
------------

// File: rtl/sobel_window_reader_pkg.sv
// sobel_pkg: shared defaults, FSM state encoding and 3x3 window packing
// for the sobel window reader and its line buffers.
package sobel_pkg;
  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int AW_DEF    = 10;
  localparam int PW_DEF    = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Slot of window pixel (row, col) in the packed window word; p00 sits in the LSBs.
  function automatic int win_idx(input int row, input int col);
    return 3 * row + col;
  endfunction
endpackage

// File: rtl/sobel_window_reader_if.sv
// sobel_window_reader_if: start/done, gray-memory read port and window
// output handshake of the sobel window reader.
//   master : the reader (drives rd_en/rd_addr/win/win_addr/win_valid/sobel_done)
//   slave  : the environment (drives sobel_en/rd_data/win_ready)
interface sobel_window_reader_if
  import sobel_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
);
  logic            sobel_en;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [3*PW-1:0] rd_data;
  logic [9*PW-1:0] win;
  logic [AW-1:0]   win_addr;
  logic            win_valid;
  logic            win_ready;
  logic            sobel_done;

  modport master (
    input  sobel_en, rd_data, win_ready,
    output rd_en, rd_addr, win, win_addr, win_valid, sobel_done
  );

  modport slave (
    output sobel_en, rd_data, win_ready,
    input  rd_en, rd_addr, win, win_addr, win_valid, sobel_done
  );
endinterface

// File: rtl/sobel_window_reader_line_buffer.sv
// line_buffer: DEPTH-deep, PW-wide delay line advanced only on en.
//   clk  : clock
//   en   : shift strobe (one per returned pixel)
//   din  : pixel in
//   dout : pixel pushed DEPTH strobes ago
// Contents are not reset; the reader never forms a window from stale rows.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int PW    = PW_DEF
) (
  input  logic          clk,
  input  logic          en,
  input  logic [PW-1:0] din,
  output logic [PW-1:0] dout
);
  logic [PW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign dout = mem_q[DEPTH-1];
endmodule

// File: rtl/sobel_window_reader.sv
// sobel_window_reader: raster-reads a gray frame and emits every interior
// 3x3 window with the address of its centre pixel.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : sobel_en start pulse, rd_en/rd_addr/rd_data read port (1-cycle
//         latency), win/win_addr/win_valid/win_ready output, sobel_done pulse
//
// state  | meaning
// IDLE   | waiting for sobel_en
// READ   | issuing one read per unstalled cycle, raster order
// FLUSH  | all reads issued, draining until the last window transfers
// DONE   | one cycle with sobel_done=1, then IDLE
module sobel_window_reader
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = AW_DEF,
  parameter int PW    = PW_DEF
) (
  input logic                   clk,
  input logic                   rst,
  sobel_window_reader_if.master bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);

  state_e          state_q;
  logic [AW-1:0]   rd_addr_q, pix_q, win_addr_q, win_addr_d;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            pend_q, skid_valid_q, win_valid_q, last_q, sobel_done_q;
  logic [PW-1:0]   skid_q, px, lb0_out, lb1_out;
  logic [PW-1:0]   sh_q [3][3];
  logic [PW-1:0]   col_new [3];
  logic [9*PW-1:0] win_q, win_d;
  logic            stall, rd_en, proc, is_win, is_last;
  logic [2*PW-1:0] rd_data_unused;

  assign rd_data_unused = bus.rd_data[3*PW-1:PW];

  // A held window blocks everything: no new reads, no pixel consumption.
  assign stall = win_valid_q && !bus.win_ready;
  assign rd_en = (state_q == S_READ) && !stall;
  // At most one of pend_q / skid_valid_q can be set on an unstalled cycle.
  assign proc  = (pend_q || skid_valid_q) && !stall;
  assign px    = skid_valid_q ? skid_q : bus.rd_data[PW-1:0];

  assign is_win     = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign is_last    = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
  assign win_addr_d = pix_q - AW'(IMG_W + 1);

  assign col_new[0] = lb1_out;
  assign col_new[1] = lb0_out;
  assign col_new[2] = px;

  always_comb begin
    win_d = '0;
    for (int i = 0; i < 3; i++) begin
      win_d[PW*win_idx(i, 0) +: PW] = sh_q[i][1];
      win_d[PW*win_idx(i, 1) +: PW] = sh_q[i][2];
      win_d[PW*win_idx(i, 2) +: PW] = col_new[i];
    end
  end

  line_buffer #(.DEPTH(IMG_W), .PW(PW)) u_lb0 (.clk(clk), .en(proc), .din(px),      .dout(lb0_out));
  line_buffer #(.DEPTH(IMG_W), .PW(PW)) u_lb1 (.clk(clk), .en(proc), .din(lb0_out), .dout(lb1_out));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      pend_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      pix_q        <= '0;
      win_q        <= '0;
      win_addr_q   <= '0;
      win_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      sobel_done_q <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) sh_q[i][j] <= '0;
    end else begin
      sobel_done_q <= 1'b0;
      pend_q       <= rd_en;

      case (state_q)
        S_IDLE: if (bus.sobel_en) begin
          state_q   <= S_READ;
          rd_addr_q <= '0;
          col_q     <= '0;
          row_q     <= '0;
          pix_q     <= '0;
          last_q    <= 1'b0;
        end
        S_READ: if (rd_en) begin
          rd_addr_q <= rd_addr_q + 1'b1;
          if (rd_addr_q == AW'(NPIX-1)) state_q <= S_FLUSH;
        end
        S_FLUSH: if (win_valid_q && bus.win_ready && last_q) begin
          state_q      <= S_DONE;
          sobel_done_q <= 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Read issued just before a stall lands here and is consumed first on release.
      if (pend_q && stall) begin
        skid_valid_q <= 1'b1;
        skid_q       <= bus.rd_data[PW-1:0];
      end else if (proc) begin
        skid_valid_q <= 1'b0;
      end

      if (proc) begin
        for (int i = 0; i < 3; i++) begin
          sh_q[i][0] <= sh_q[i][1];
          sh_q[i][1] <= sh_q[i][2];
          sh_q[i][2] <= col_new[i];
        end
        pix_q <= pix_q + 1'b1;
        if (col_q == CW'(IMG_W-1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(IMG_H-1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      if (proc && is_win) begin
        win_q       <= win_d;
        win_addr_q  <= win_addr_d;
        win_valid_q <= 1'b1;
        last_q      <= is_last;
      end else if (bus.win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.win        = win_q;
  assign bus.win_addr   = win_addr_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.sobel_done = sobel_done_q;
endmodule
